// File: rtl/raw_pack.sv
// raw_pack: packs 1bpp/2bpp MSB-first pixels into bytes and queues them in a small valid/ready FIFO.
// Build option RAW_PACK_FLUSH_EN: LineEnd pushes a zero-padded partial byte instead of discarding it.
module raw_pack #(
  parameter int DEPTH = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [1:0] Pixel,
  input  logic       PixelValid,
  input  logic       Divider,
  input  logic       LineEnd,
  output logic [7:0] Data,
  output logic       DataValid,
  input  logic       DataReady,
  output logic       Overflow,
  input  logic       ClearOvf
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_acc;
  logic [2:0]  r_cnt;
  logic        r_mode;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        r_ovf;

  logic        w_mode;
  logic [7:0]  w_accPix;
  logic [3:0]  w_cntSum;
  logic [2:0]  w_cntPix;
  logic        w_complete;
  logic        w_lineCut;
  logic        w_push;
  logic [7:0]  w_pushData;
  logic [7:0]  w_accNext;
  logic [2:0]  w_cntNext;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_write;
  logic        w_drop;

  // Pixel is packed first; a LineEnd then acts on whatever partial byte remains.
  always_comb begin
    w_mode   = r_mode;
    w_accPix = r_acc;
    w_cntSum = {1'b0, r_cnt};
    if (PixelValid) begin
      if (r_cnt == 3'd0) begin
        w_mode = Divider;
      end
      if (w_mode) begin
        w_accPix = {r_acc[5:0], Pixel};
        w_cntSum = {1'b0, r_cnt} + 4'd2;
      end else begin
        w_accPix = {r_acc[6:0], Pixel[0]};
        w_cntSum = {1'b0, r_cnt} + 4'd1;
      end
    end
    w_cntPix   = w_cntSum[2:0];
    w_complete = w_cntSum[3];
    w_lineCut  = LineEnd && !w_complete && (w_cntPix != 3'd0);

    w_push     = w_complete;
    w_pushData = w_accPix;
    w_accNext  = w_complete ? 8'h00 : w_accPix;
    w_cntNext  = w_cntPix;
    if (w_lineCut) begin
      w_accNext = 8'h00;
      w_cntNext = 3'd0;
`ifdef RAW_PACK_FLUSH_EN
      w_push     = 1'b1;
      w_pushData = w_accPix << (4'd8 - {1'b0, w_cntPix});
`endif
    end
  end

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = !w_empty && DataReady;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_acc   <= 8'h00;
      r_cnt   <= 3'd0;
      r_mode  <= 1'b0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_acc  <= w_accNext;
      r_cnt  <= w_cntNext;
      r_mode <= w_mode;
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ClearOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_write) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_pushData;
    end
  end

  assign Data      = w_empty ? 8'h00 : r_mem[r_rdPtr[AW-1:0]];
  assign DataValid = !w_empty;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_raw_pack.sv
// tb_raw_pack: table-driven vectors, hand-written corner sequences and randomized traffic
// checked against a byte-level reference model of raw_pack.
module tb_raw_pack;

  localparam int DEPTH = 2;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] Pixel = 2'd0;
  logic       PixelValid = 1'b0;
  logic       Divider = 1'b0;
  logic       LineEnd = 1'b0;
  logic       DataReady = 1'b0;
  logic       ClearOvf = 1'b0;
  logic [7:0] Data;
  logic       DataValid;
  logic       Overflow;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  raw_pack #(.DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Pixel      (Pixel),
    .PixelValid (PixelValid),
    .Divider    (Divider),
    .LineEnd    (LineEnd),
    .Data       (Data),
    .DataValid  (DataValid),
    .DataReady  (DataReady),
    .Overflow   (Overflow),
    .ClearOvf   (ClearOvf)
  );

  typedef struct {
    logic       pv;
    logic [1:0] pix;
    logic       div;
    logic       le;
    logic       rdy;
    logic       clr;
    logic       expValid;
    logic [7:0] expData;
    logic       expOvf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pixels accumulated as an integer, FIFO as a queue of bytes
  int          mBits;
  int          mVal;
  logic        mMode;
  byte unsigned mQ[$];
  logic        mOvf;

  logic       rPv;
  logic [1:0] rPix;
  logic       rDiv;
  logic       rLe;
  logic       rRdy;
  logic       rClr;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [7:0] d, input logic o);
    checkOutput({tag, ".valid"}, {7'd0, DataValid}, {7'd0, v});
    checkOutput({tag, ".data"}, Data, d);
    checkOutput({tag, ".ovf"}, {7'd0, Overflow}, {7'd0, o});
  endtask

  task automatic applyStimulus(input logic pv, input logic [1:0] pix, input logic div,
                               input logic le, input logic rdy, input logic clr);
    PixelValid = pv;
    Pixel      = pix;
    Divider    = div;
    LineEnd    = le;
    DataReady  = rdy;
    ClearOvf   = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic sendByte1(input logic [7:0] b, input logic rdy, input logic rdyLast);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, {1'b0, b[i]}, 1'b0, 1'b0, (i == 0) ? rdyLast : rdy, 1'b0);
    end
  endtask

  task automatic addVec(input logic pv, input logic [1:0] pix, input logic div, input logic le,
                        input logic rdy, input logic clr, input logic ev, input logic [7:0] ed,
                        input logic eo);
    vec_t v;
    v.pv = pv; v.pix = pix; v.div = div; v.le = le; v.rdy = rdy; v.clr = clr;
    v.expValid = ev; v.expData = ed; v.expOvf = eo;
    vecs.push_back(v);
  endtask

  task automatic modelReset();
    mBits = 0;
    mVal  = 0;
    mMode = 1'b0;
    mQ.delete();
    mOvf  = 1'b0;
  endtask

  task automatic modelStep(input logic pv, input logic [1:0] pix, input logic div,
                           input logic le, input logic rdy, input logic clr);
    bit pop;
    bit full;
    bit drop;
    int pushVal;
    pop     = (mQ.size() > 0) && rdy;
    full    = (mQ.size() == DEPTH);
    pushVal = -1;
    if (pv) begin
      if (mBits == 0) mMode = div;
      if (mMode) begin
        mVal  = mVal * 4 + int'(pix);
        mBits = mBits + 2;
      end else begin
        mVal  = mVal * 2 + int'(pix[0]);
        mBits = mBits + 1;
      end
      if (mBits == 8) begin
        pushVal = mVal;
        mBits   = 0;
        mVal    = 0;
      end
    end
    if (le && mBits != 0) begin
`ifdef RAW_PACK_FLUSH_EN
      pushVal = mVal * (1 << (8 - mBits));
`endif
      mBits = 0;
      mVal  = 0;
    end
    drop = (pushVal >= 0) && full && !pop;
    if (pop) void'(mQ.pop_front());
    if (pushVal >= 0 && !drop) mQ.push_back(8'(pushVal));
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  initial begin
    logic [7:0] pat1;
    logic [1:0] pix2 [4];
    logic       div2 [4];
    logic [7:0] expD;

    // 1bpp 8'hA5 then 2bpp 8'hC9 with a Divider flip mid-byte
    pat1 = 8'b1010_0101;
    for (int i = 7; i >= 0; i--) begin
      addVec(1'b1, {1'b0, pat1[i]}, 1'b0, 1'b0, 1'b1, 1'b0,
             i == 0, (i == 0) ? 8'hA5 : 8'h00, 1'b0);
    end
    addVec(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    pix2 = '{2'b11, 2'b00, 2'b10, 2'b01};
    div2 = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      addVec(1'b1, pix2[i], div2[i], 1'b0, 1'b1, 1'b0,
             i == 3, (i == 3) ? 8'hC9 : 8'h00, 1'b0);
    end
    addVec(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    repeat (2) @(posedge Clk);
    #1;
    checkAll("reset", 1'b0, 8'h00, 1'b0);
    @(negedge Clk);
    nReset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pv, vecs[i].pix, vecs[i].div, vecs[i].le, vecs[i].rdy, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, vecs[i].expOvf);
    end

    // Overflow with DataReady held low, then drain and clear
    sendByte1(8'h01, 1'b0, 1'b0);
    checkAll("ovf.b1", 1'b1, 8'h01, 1'b0);
    sendByte1(8'h02, 1'b0, 1'b0);
    checkAll("ovf.b2", 1'b1, 8'h01, 1'b0);
    sendByte1(8'h03, 1'b0, 1'b0);
    checkAll("ovf.b3", 1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("ovf.pop1", 1'b1, 8'h02, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("ovf.pop2", 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkAll("ovf.clear", 1'b0, 8'h00, 1'b0);

    // Push and pop together while full
    sendByte1(8'h11, 1'b0, 1'b0);
    sendByte1(8'h22, 1'b0, 1'b0);
    checkAll("full.pre", 1'b1, 8'h11, 1'b0);
    sendByte1(8'h33, 1'b0, 1'b1);
    checkAll("full.pushpop", 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("full.drain1", 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("full.drain2", 1'b0, 8'h00, 1'b0);

    // LineEnd after three 1bpp pixels
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef RAW_PACK_FLUSH_EN
    checkAll("line.flush", 1'b1, 8'hE0, 1'b0);
`else
    checkAll("line.discard", 1'b0, 8'h00, 1'b0);
`endif
    sendByte1(8'h5A, 1'b1, 1'b1);
    checkAll("line.next", 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("line.drain", 1'b0, 8'h00, 1'b0);

    // Reset mid-byte with bytes queued and Overflow set
    sendByte1(8'h77, 1'b0, 1'b0);
    sendByte1(8'h78, 1'b0, 1'b0);
    sendByte1(8'h79, 1'b0, 1'b0);
    checkAll("rst.pre", 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    nReset = 1'b0;
    #2;
    checkAll("rst.async", 1'b0, 8'h00, 1'b0);
    @(negedge Clk);
    nReset = 1'b1;
    sendByte1(8'hC3, 1'b0, 1'b0);
    checkAll("rst.byte", 1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("rst.only", 1'b0, 8'h00, 1'b0);

    // Randomized traffic against the model, sustained DataReady first
    nReset = 1'b0;
    #2;
    @(negedge Clk);
    nReset = 1'b1;
    modelReset();
    rDiv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rPv  = ($urandom_range(0, 9) < 7);
      rPix = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rDiv = ~rDiv;
      rLe  = ($urandom_range(0, 15) == 0);
`ifndef RAW_PACK_FLUSH_EN
      if (rPv) rLe = 1'b0;
`endif
      rRdy = (c < 500) ? 1'b1 : 1'($urandom_range(0, 1));
      rClr = ($urandom_range(0, 15) == 0);
      modelStep(rPv, rPix, rDiv, rLe, rRdy, rClr);
      applyStimulus(rPv, rPix, rDiv, rLe, rRdy, rClr);
      expD = (mQ.size() > 0) ? mQ[0] : 8'h00;
      checkAll($sformatf("rand%0d", c), mQ.size() > 0, expD, mOvf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/raw_pack.md
# raw_pack

Pixel-to-byte packer for the VDG pixel path: the inverse of the display shift register. Accepts a stream of 1-bit or 2-bit pixels, MSB-first, reassembles them into bytes and presents them through a small FIFO with a valid/ready handshake. Used for video readback/capture and as the loop-back checker for the display shifter.

## Interface
Parameters:
- DEPTH, 2, FIFO depth in bytes (power of two, 2..8)

Ports:
- Clk  input  1  pixel clock, all logic on rising edge
- nReset  input  1  reset, asynchronous, active-low
- Pixel  input  2  incoming pixel; 1bpp uses Pixel[0], Pixel[1] ignored
- PixelValid  input  1  Pixel is sampled this cycle
- Divider  input  1  0 = 1bpp (8 pixels/byte), 1 = 2bpp (4 pixels/byte)
- LineEnd  input  1  end-of-line marker, sampled with or without PixelValid
- Data  output  8  FIFO head byte
- DataValid  output  1  Data holds a valid byte
- DataReady  input  1  consumer accepts Data when DataValid & DataReady
- Overflow  output  1  sticky: a completed byte was dropped
- ClearOvf  input  1  synchronous clear of Overflow

## Operation
- Accumulator: 8-bit shift register Acc, pixel count Cnt (0..7), latched mode M.
- On PixelValid with Cnt == 0: M <= Divider. Divider changes mid-byte are ignored until the next byte starts.
- M = 0: Acc <= {Acc[6:0], Pixel[0]}, Cnt += 1; byte complete when 8th pixel sampled.
- M = 1: Acc <= {Acc[5:0], Pixel}, Cnt += 2; byte complete when 4th pixel sampled.
- The first pixel of a byte lands in bit 7 (1bpp) or bits 7:6 (2bpp). A byte packed here and loaded into the display shifter reproduces the same pixel sequence.
- On completion, the assembled byte is pushed to the FIFO, and Cnt <= 0.
- FIFO: DEPTH entries, read/write pointers one bit wider than the address (full/empty by MSB compare).
- Pop occurs on DataValid & DataReady.
- Push while full and no pop in the same cycle: byte dropped, Overflow <= 1. Accumulator still resets.
- Push and pop in the same cycle while full: both occur, no overflow.
- Push and pop in the same cycle while empty: the byte enters the FIFO and is not bypassed. DataValid rises next cycle.
- Overflow clears only on reset or ClearOvf. If ClearOvf and a new drop coincide, the drop wins and Overflow = 1.
- Data and DataValid are stable while DataValid & !DataReady.

## Timing
- Reset (async assert, sync-released by the system): Acc = 0, Cnt = 0, M = 0, FIFO empty, DataValid = 0, Data = 8'h00, Overflow = 0.
- Latency: byte completes on edge N; DataValid = 1 with that byte after edge N (visible in cycle N+1).
- Throughput: one byte per 4 (2bpp) or 8 (1bpp) PixelValid cycles; a sustained DataReady = 1 never overflows.
- Reset mid-byte discards the partial byte and all FIFO contents; no partial push.
- Gaps in PixelValid stall packing; Cnt holds.

## Configuration
- RAW_PACK_FLUSH_EN defined:
  - LineEnd with Cnt != 0 pads the remaining low bits with 0 and pushes the partial byte, then Cnt <= 0.
  - If PixelValid and LineEnd coincide, the pixel is packed first; flush then applies to the result, and a byte just completed by that pixel is not pushed twice.
- RAW_PACK_FLUSH_EN undefined:
  - LineEnd with Cnt != 0 discards the partial byte (Cnt <= 0, Acc <= 0) with no push.
  - LineEnd with Cnt == 0 has no effect in either build.

## Test plan
- 1bpp: pixels 1,0,1,0,0,1,0,1 with DataReady = 1 -> Data = 8'hA5, DataValid high for one cycle, one cycle after the 8th pixel.
- 2bpp: pixels 2'b11,2'b00,2'b10,2'b01 -> Data = 8'hC9. Divider toggled after the 2nd pixel is ignored for that byte.
- DataReady = 0, DEPTH = 2: three complete 1bpp bytes 8'h01, 8'h02, 8'h03 -> FIFO holds 01,02; Overflow = 1; releasing DataReady yields 01 then 02; ClearOvf -> Overflow = 0.
- Full FIFO with push and pop in the same cycle -> no Overflow, order preserved.
- LineEnd after 3 pixels 1,1,1 (1bpp) -> flush build: Data = 8'hE0 pushed; non-flush build: no DataValid, next 8 pixels form a clean byte.
- nReset asserted mid-byte with 1 byte queued -> DataValid = 0, Overflow = 0 immediately; the next 8 pixels produce exactly one correct byte.
